// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between the MEM stage and the data memory.
// The MEM stage is the master; the memory (or a testbench model) is the slave.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a two-state IDLE/ACCESS memory FSM,
// little-endian byte enables, store-lane replication, load lane extraction
// with sign/zero extension, and a dmem_ready wait timeout (DMEM_TIMEOUT).
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with an align_err pulse; otherwise misaligned addresses are
// force-aligned and align_err is tied low.
module mem_stage #(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_unsigned,
    input  logic [1:0]  ex_size,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_write_reg,
    input  logic [1:0]  ex_control_wb,
    mem_stage_if.master bus,
    output logic [1:0]  control_wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output logic        stall,
    output logic        mem_err,
    output logic        align_err
);

    localparam int CW = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(DMEM_TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;

    logic [31:0] addr_q, wdata_q;
    logic        we_q, unsigned_q;
    logic [1:0]  size_q, control_wb_q;
    logic [4:0]  write_reg_q;

    logic        mem_op, align_fault, start_access;
    logic        access_done, timeout, req;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wd, lane_data, load_data;

    assign mem_op = ex_valid && (ex_memread || ex_memwrite);

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned  = (ex_size == 2'b01) ? ex_addr[0]
                                            : (ex_size[1] && (ex_addr[1:0] != 2'b00));
    assign align_fault = mem_op && misaligned;
`else
    assign align_fault = 1'b0;
`endif

    assign start_access = mem_op && !align_fault;

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state and handshake decode; dmem_ready only matters during ACCESS
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        req         = 1'b0;
        access_done = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (start_access) begin
                    stall      = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                req   = 1'b1;
                stall = !bus.dmem_ready;
                if (bus.dmem_ready) begin
                    access_done = 1'b1;
                    next_state  = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    // Count ACCESS cycles spent waiting for dmem_ready; cleared otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           wait_cnt <= '0;
        else if (state == ACCESS && !access_done && !timeout) wait_cnt <= wait_cnt + 1'b1;
        else                                               wait_cnt <= '0;
    end

    // Capture the memory op when it is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= '0;
            control_wb_q <= '0;
            write_reg_q  <= '0;
        end else if (state == IDLE && start_access) begin
            addr_q       <= ex_addr;
            wdata_q      <= ex_wdata;
            we_q         <= ex_memwrite;
            unsigned_q   <= ex_unsigned;
            size_q       <= ex_size;
            control_wb_q <= ex_control_wb;
            write_reg_q  <= ex_write_reg;
        end
    end

    // Lane offset (force-aligned for half/word), byte enables and store replication
    always_comb begin
        off = addr_q[1:0];
        be  = 4'b0000;
        wd  = 32'd0;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << off;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                off[0] = 1'b0;
                be     = 4'b0011 << {off[1], 1'b0};
                wd     = {2{wdata_q[15:0]}};
            end
            default: begin
                off = 2'b00;
                be  = 4'b1111;
                wd  = wdata_q;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it to 32 bits
    always_comb begin
        lane_data = bus.dmem_rdata >> {off, 3'b000};
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'd0, lane_data[7:0]}
                                            : {{24{lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = unsigned_q ? {16'd0, lane_data[15:0]}
                                            : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    assign bus.dmem_req   = req;
    assign bus.dmem_we    = req && we_q;
    assign bus.dmem_addr  = req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.dmem_be    = req ? be : 4'b0000;
    assign bus.dmem_wdata = (req && we_q) ? wd : 32'd0;

    // MEM/WB register: completed access, bubble on stall/fault, or pass-through op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control_wb_out <= '0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            write_reg_out  <= '0;
        end else if (access_done) begin
            control_wb_out <= control_wb_q;
            read_data_out  <= we_q ? 32'd0 : load_data;
            alu_result_out <= addr_q;
            write_reg_out  <= write_reg_q;
        end else if (stall || timeout || align_fault) begin
            control_wb_out <= 2'b00;
        end else if (state == IDLE) begin
            control_wb_out <= ex_valid ? ex_control_wb : 2'b00;
            read_data_out  <= 32'd0;
            alu_result_out <= ex_addr;
            write_reg_out  <= ex_write_reg;
        end
    end

    // One-cycle error pulse when the wait for dmem_ready expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_err <= 1'b0;
        else     mem_err <= timeout;
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle pulse when a misaligned half/word op is rejected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) align_err <= 1'b0;
        else     align_err <= (state == IDLE) && align_fault;
    end
`else
    assign align_err = 1'b0;
`endif

endmodule
